// File: rtl/fake_psx_controller.sv
// Responder end of the PSX pad link: emulates a digital pad on the host's serial bus.
// Inputs are oversampled in the clk domain; command bits shift in and reply bits shift out
// LSB first, with an ack pulse after every non-final byte.
// Optional build macro ANALOG_MODE_EN adds the sticks port, ID 0x73 and a 9-byte frame.
module fake_psx_controller #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_DELAY   = 4,
    parameter int unsigned ACK_WIDTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic        att,
    input  logic [15:0] buttons,
`ifdef ANALOG_MODE_EN
    input  logic [31:0] sticks,
`endif
    output logic        data,
    output logic        ack,
    output logic        busy,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    output logic        poll_done
);

`ifdef ANALOG_MODE_EN
    localparam logic [7:0] ID_BYTE  = 8'h73;
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [7:0] ID_BYTE  = 8'h41;
    localparam logic [3:0] LAST_IDX = 4'd4;
`endif

    localparam int unsigned CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {StIdle, StShift, StAckWait, StAckPulse, StDone, StIgnore} state_e;

    // Bit 0 = psx_clk, bit 1 = att, bit 2 = cmd; all idle high.
    logic [2:0] sync_q [SYNC_STAGES];
    logic [1:0] prev_q;
    logic       clk_s, att_s, cmd_s;
    logic       clk_rise, clk_fall, att_rise, att_fall;

    state_e           state_q, state_d;
    logic [7:0]       tx_q, tx_d, rx_q, rx_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d, byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_q, data_d, ack_q, ack_d, busy_q, busy_d;
    logic [7:0]       cmd_byte_q, cmd_byte_d;
    logic             cmd_valid_q, cmd_valid_d, poll_done_q, poll_done_d;
    logic [15:0]      btn_q, btn_d;
`ifdef ANALOG_MODE_EN
    logic [31:0]      sticks_q, sticks_d;
`endif
    logic [3:0]       nxt_idx;
    logic [7:0]       nxt_reply;

    // Input synchronizers plus one extra stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= 3'b111;
            prev_q <= 2'b11;
        end else begin
            sync_q[0] <= {cmd, att, psx_clk};
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1][1:0];
        end
    end

    assign clk_s    = sync_q[SYNC_STAGES-1][0];
    assign att_s    = sync_q[SYNC_STAGES-1][1];
    assign cmd_s    = sync_q[SYNC_STAGES-1][2];
    assign clk_rise = clk_s & ~prev_q[0];
    assign clk_fall = ~clk_s & prev_q[0];
    assign att_rise = att_s & ~prev_q[1];
    assign att_fall = ~att_s & prev_q[1];

    // Reply byte for the slot after the current one, built from the snapshot.
    always_comb begin
        nxt_idx = byte_idx_q + 4'd1;
        unique case (nxt_idx)
            4'd1:    nxt_reply = ID_BYTE;
            4'd2:    nxt_reply = 8'h5A;
            4'd3:    nxt_reply = btn_q[7:0];
            4'd4:    nxt_reply = btn_q[15:8];
`ifdef ANALOG_MODE_EN
            4'd5:    nxt_reply = sticks_q[7:0];
            4'd6:    nxt_reply = sticks_q[15:8];
            4'd7:    nxt_reply = sticks_q[23:16];
            4'd8:    nxt_reply = sticks_q[31:24];
`endif
            default: nxt_reply = 8'hFF;
        endcase
    end

    // Frame FSM next-state and registered-output logic; att rise aborts from any state.
    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        byte_idx_d  = byte_idx_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        ack_d       = ack_q;
        busy_d      = busy_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = 1'b0;
        poll_done_d = 1'b0;
        btn_d       = btn_q;
`ifdef ANALOG_MODE_EN
        sticks_d    = sticks_q;
`endif
        if (att_rise) begin
            state_d = StIdle;
            data_d  = 1'b1;
            ack_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (att_fall) begin
                        tx_d       = 8'hFF;
                        data_d     = 1'b1;
                        busy_d     = 1'b1;
                        bit_cnt_d  = 4'd0;
                        byte_idx_d = 4'd0;
                        state_d    = StShift;
                    end
                end
                StShift: begin
                    if (bit_cnt_q == 4'd8) begin
                        cmd_byte_d  = rx_q;
                        cmd_valid_d = 1'b1;
                        data_d      = 1'b1;
                        if ((byte_idx_q == 4'd0 && rx_q != 8'h01) ||
                            (byte_idx_q == 4'd1 && rx_q != 8'h42)) begin
                            state_d = StIgnore;
                            busy_d  = 1'b0;
                        end else begin
                            if (byte_idx_q == 4'd1) begin
                                btn_d = buttons;
`ifdef ANALOG_MODE_EN
                                sticks_d = sticks;
`endif
                            end
                            if (byte_idx_q == LAST_IDX) begin
                                poll_done_d = 1'b1;
                                state_d     = StDone;
                            end else begin
                                cnt_d   = '0;
                                state_d = StAckWait;
                            end
                        end
                    end else if (clk_rise) begin
                        rx_d      = {cmd_s, rx_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (clk_fall && bit_cnt_q != 4'd0) begin
                        // The first fall of a byte keeps bit 0, which is already on the pin.
                        tx_d   = {1'b1, tx_q[7:1]};
                        data_d = tx_q[1];
                    end
                end
                StAckWait: begin
                    if (cnt_q == CNT_W'(ACK_DELAY - 1)) begin
                        cnt_d   = '0;
                        ack_d   = 1'b1;
                        tx_d    = nxt_reply;
                        data_d  = nxt_reply[0];
                        state_d = StAckPulse;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StAckPulse: begin
                    if (cnt_q == CNT_W'(ACK_WIDTH - 1)) begin
                        cnt_d      = '0;
                        ack_d      = 1'b0;
                        byte_idx_d = byte_idx_q + 4'd1;
                        bit_cnt_d  = 4'd0;
                        state_d    = StShift;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StDone, StIgnore: begin
                    data_d = 1'b1;
                    ack_d  = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            tx_q        <= 8'hFF;
            rx_q        <= 8'h00;
            bit_cnt_q   <= 4'd0;
            byte_idx_q  <= 4'd0;
            cnt_q       <= '0;
            data_q      <= 1'b1;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            cmd_byte_q  <= 8'h00;
            cmd_valid_q <= 1'b0;
            poll_done_q <= 1'b0;
            btn_q       <= 16'hFFFF;
`ifdef ANALOG_MODE_EN
            sticks_q    <= 32'h0;
`endif
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_idx_q  <= byte_idx_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_valid_q <= cmd_valid_d;
            poll_done_q <= poll_done_d;
            btn_q       <= btn_d;
`ifdef ANALOG_MODE_EN
            sticks_q    <= sticks_d;
`endif
        end
    end

    assign data      = data_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign cmd_byte  = cmd_byte_q;
    assign cmd_valid = cmd_valid_q;
    assign poll_done = poll_done_q;

endmodule
